// File: rtl/rc_sub_sequencer.sv
// Multi-cycle W-bit subtractor controller that sequences one external 4-bit
// ripple-borrow slice, least-significant nibble first, chaining borrow via a register.
module rc_sub_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 bout,
    output logic                 zero,
    output logic                 ovf,
    output logic [3:0]           sl_a,
    output logic [3:0]           sl_b,
    output logic                 sl_bin,
    input  logic [3:0]           sl_d,
    input  logic                 sl_bout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   diff_q, diff_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           br_q, br_d;
    logic           a_msb_q, a_msb_d;
    logic           b_msb_q, b_msb_d;
    logic           bout_q, bout_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   acc_shift;

    // Slice result enters the accumulator at the MSB end; after NIBBLES shifts it is aligned.
    assign acc_shift = (acc_q >> 4) | (W'(sl_d) << (W - 4));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_RUN: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                acc_d = acc_shift;
                br_d  = sl_bout;
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    diff_d  = acc_shift;
                    bout_d  = sl_bout;
                    zero_d  = (acc_shift == '0);
                    ovf_d   = (a_msb_q != b_msb_q) && (acc_shift[W-1] != a_msb_q);
                    // Borrow chain is parked at 0 so the slice sees idle inputs outside RUN.
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    br_d    = bin;
                    a_msb_d = op_a[W-1];
                    b_msb_d = op_b[W-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A/B shift in zeros, so their low nibbles are already 0 outside RUN.
    assign sl_a   = a_q[3:0];
    assign sl_b   = b_q[3:0];
    assign sl_bin = br_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign bout   = bout_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_rc_sub_sequencer.sv
// Scoreboard bench for rc_sub_sequencer with NIBBLES=4 and a behavioural slice.
module tb_rc_sub_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        bin;
    logic        busy, done, bout, zero, ovf;
    logic [15:0] diff;
    logic [3:0]  sl_a, sl_b, sl_d;
    logic        sl_bin, sl_bout;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        b;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural 4-bit ripple-borrow slice
    assign sl_d    = 4'(sl_a - sl_b - {3'b000, sl_bin});
    assign sl_bout = ({1'b0, sl_a} < ({1'b0, sl_b} + {4'b0000, sl_bin}));

    rc_sub_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf),
        .sl_a(sl_a), .sl_b(sl_b), .sl_bin(sl_bin), .sl_d(sl_d), .sl_bout(sl_bout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("bout", 32'(bout), 32'(e.b));
                chk("zero", 32'(zero), 32'(e.z));
                chk("ovf",  32'(ovf),  32'(e.o));
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
        @(negedge clk);
        op_a = a; op_b = b; bin = bi; start = 1'b1;
        sb.push_back(exp_t'{d: ed, b: eb, z: ez, o: eo});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("sl_a_seq", 32'(sl_a), 32'(a[4*k +: 4]));
            chk("sl_b_seq", 32'(sl_b), 32'(b[4*k +: 4]));
            @(negedge clk);
        end
        chk("done_at_e4", 32'(done), 32'd1);
        chk("busy_at_e4", 32'(busy), 32'd0);
        chk("sl_a_idle",  32'(sl_a), 32'd0);
        chk("sl_bin_idle", 32'(sl_bin), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; bin = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", 32'({bout, zero, ovf}), 32'd0);
        chk("rst_slice", 32'({sl_a, sl_b, sl_bin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op(16'h0001, 16'h0003, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);

        // Start held through RUN with changing operands, then accepted in DONE
        @(negedge clk);
        op_a = 16'h4321; op_b = 16'h1111; bin = 1'b0; start = 1'b1;
        sb.push_back(exp_t'{d: 16'h3210, b: 1'b0, z: 1'b0, o: 1'b0});
        @(posedge clk);
        @(negedge clk);
        op_a = 16'h0100; op_b = 16'h0001; bin = 1'b1;
        sb.push_back(exp_t'{d: 16'h00FE, b: 1'b0, z: 1'b0, o: 1'b0});
        for (int k = 0; k < 4; k++) begin
            chk("b2b_busy", 32'(busy), 32'd1);
            chk("b2b_sl_a", 32'(sl_a), 32'(k == 0 ? 1 : k == 1 ? 2 : k == 2 ? 3 : 4));
            @(negedge clk);
        end
        chk("b2b_done1", 32'(done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy2", 32'(busy), 32'd1);
        chk("b2b_sl_a2", 32'(sl_a), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("b2b_nodone", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("b2b_done2", 32'(done), 32'd1);
        @(negedge clk);
        chk("b2b_pulse", 32'(done), 32'd0);

        // Reset mid-RUN abandons the operation
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_diff", 32'(diff), 32'd0);
        chk("mid_flags", 32'({bout, zero, ovf}), 32'd0);
        chk("mid_slice", 32'({sl_a, sl_b, sl_bin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({busy, done}), 32'd0);
        end
        run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rc_sub_sequencer.md
# rc_sub_sequencer

Multi-cycle controller that performs a W-bit subtraction (W = 4·NIBBLES) by sequencing one external 4-bit ripple-carry subtractor slice, least-significant nibble first. The borrow is chained through a register between passes. It sits between a requesting datapath (start/done handshake) and the shared combinational `rc_subtractor` slice. It holds the final difference, borrow, zero and signed-overflow flags until the next accepted request.

## Interface
- NIBBLES, 4, number of 4-bit passes; operand width W = 4·NIBBLES; legal range 1..16
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled on rising edge when state is IDLE or DONE
- op_a  in  W  minuend; sampled with an accepted start
- op_b  in  W  subtrahend; sampled with an accepted start
- bin  in  1  initial borrow-in; sampled with an accepted start
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse; result outputs are valid and stable
- diff  out  W  result register: (op_a − op_b − bin) mod 2^W
- bout  out  1  final borrow-out: 1 when op_a < op_b + bin (unsigned)
- zero  out  1  diff == 0
- ovf  out  1  signed overflow of op_a − op_b − bin
- sl_a  out  4  slice minuend nibble
- sl_b  out  4  slice subtrahend nibble
- sl_bin  out  1  slice borrow-in
- sl_d  in  4  slice difference; combinational from sl_a/sl_b/sl_bin
- sl_bout  in  1  slice borrow-out

## Operation
- Slice contract: sl_d = (sl_a − sl_b − sl_bin) mod 16, and sl_bout = (sl_a < sl_b + sl_bin). The slice is purely combinational and its result settles within one cycle.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start = 1: load shift registers A ← op_a and B ← op_b, load borrow register br ← bin, set count ← 0, clear the accumulator, then go to RUN.
  - Otherwise remain in IDLE.
- RUN, once per cycle:
  - Drive sl_a = A[3:0], sl_b = B[3:0], sl_bin = br.
  - On the edge:
    - Shift sl_d into the accumulator from the MSB end.
    - Shift A and B right by 4.
    - Set br ← sl_bout and count ← count + 1.
  - On the edge where count = NIBBLES−1:
    - Load diff ← final accumulator value, including that edge's sl_d.
    - Load bout ← sl_bout.
    - Load zero and ovf from that final result.
    - Go to DONE.
- ovf = (a[W−1] ≠ b[W−1]) ∧ (diff[W−1] ≠ a[W−1]), using the captured operand MSBs.
- DONE:
  - done = 1 for exactly one cycle.
  - On start = 1: accept exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- start in RUN is ignored; op_a, op_b and bin may change freely in RUN without effect.
- sl_a, sl_b and sl_bin are 0 in IDLE and DONE.
- diff, bout, zero and ovf change only on the RUN→DONE edge and hold otherwise.
- NIBBLES = 1: RUN lasts one cycle.

## Timing
- Reset (asynchronous, rst_n low):
  - State becomes IDLE.
  - busy, done, diff, bout, zero and ovf all go to 0.
  - sl_a, sl_b and sl_bin go to 0.
  - All internal registers are cleared.
- Reset mid-RUN abandons the operation: no done pulse follows, and outputs read 0.
- Start accepted at edge E:
  - busy = 1 from edge E to edge E+NIBBLES.
  - Nibble k is presented to the slice between edges E+k and E+k+1.
- done = 1 between edges E+NIBBLES and E+NIBBLES+1, with the result already valid.
- Earliest next accept is edge E+NIBBLES+1, with start high during DONE. Sustained throughput is one operation per NIBBLES+1 cycles.
- No combinational path from start or op_* to any output. The only combinational path is sl_d/sl_bout → internal registers.

## Test plan
All scenarios use NIBBLES = 4 and a behavioural slice model.
- Basic subtract: 0x1234 − 0x0234, bin = 0.
  - Result: diff = 0x1000, bout = 0, zero = 0, ovf = 0.
  - sl_a sequence is 4, 3, 2, 1 on consecutive cycles.
  - done is high exactly in cycle E+4.
- Unsigned underflow: 0x0001 − 0x0003, bin = 0 → diff = 0xFFFE, bout = 1, ovf = 0, zero = 0.
- Signed overflow: 0x8000 − 0x0001 → diff = 0x7FFF, bout = 0, ovf = 1.
- Borrow-in gives zero: 0x0005 − 0x0004, bin = 1 → diff = 0x0000, zero = 1, bout = 0.
- Ignored start, then back-to-back:
  - Change op_a/op_b and hold start high through RUN: the first result is unaffected.
  - The start seen during DONE is accepted and produces the second result in cycle E+9.
- Reset mid-RUN: assert rst_n low at cycle E+2.
  - All outputs read 0 immediately.
  - No done pulse follows.
  - The next start (0x00FF − 0x000F) yields 0x00F0.
